// File: rtl/gcn_seq_pkg.sv
// Shared types and default constants for the GCN phase sequencer.
package gcn_seq_pkg;

  localparam int unsigned DEF_FEATURE_BASE_ADDR = 512;
  localparam int unsigned DEF_READ_LATENCY      = 2;
  localparam int unsigned READ_LATENCY_MIN      = 1;
  localparam int unsigned READ_LATENCY_MAX      = 4;
  localparam int unsigned LAT_W                 = $clog2(READ_LATENCY_MAX + 1);

  typedef enum logic [3:0] {
    IDLE,
    LOAD_W,
    WAIT_W,
    READ_F,
    DRAIN_F,
    AGG,
    DRAIN_A,
    CLASS,
    DONE
  } gcn_seq_state_t;

endpackage

// File: rtl/gcn_seq_delay_line.sv
// Valid-tagged shift register that aligns write strobes to the memory read latency.
module gcn_seq_delay_line #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0] vld_q;
  logic [WIDTH-1:0] dat_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= in_valid;
      dat_q[0] <= in_data;
      for (int i = 1; i < int'(DEPTH); i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_data  = dat_q[DEPTH-1];

endmodule

// File: rtl/gcn_phase_sequencer.sv
// Transform / aggregate / classify phase controller for the GCN datapath.
// Optional cycle counter output perf_cycles when GCN_SEQ_PERF_EN is defined.
module gcn_phase_sequencer
  import gcn_seq_pkg::*;
#(
  parameter int unsigned WEIGHT_COLS       = 3,
  parameter int unsigned FEATURE_ROWS      = 6,
  parameter int unsigned COO_NUM_OF_COLS   = 6,
  parameter int unsigned ADDRESS_WIDTH     = 13,
  parameter int unsigned FEATURE_BASE_ADDR = DEF_FEATURE_BASE_ADDR,
  parameter int unsigned READ_LATENCY      = DEF_READ_LATENCY,
  parameter int unsigned COO_BW            = $clog2(COO_NUM_OF_COLS),
  parameter int unsigned ROW_W             = $clog2(FEATURE_ROWS),
  parameter int unsigned COL_W             = $clog2(WEIGHT_COLS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic [ADDRESS_WIDTH-1:0] read_address,
  output logic                     enable_read,
  output logic [COO_BW-1:0]        coo_address,
  output logic                     wm_load_en,
  output logic                     fm_wm_wr_en,
  output logic [ROW_W-1:0]         fm_wm_wr_row,
  output logic [COL_W-1:0]         fm_wm_wr_col,
  output logic                     agg_wr_en,
  output logic                     class_en,
  output logic [ROW_W-1:0]         class_row,
  output logic                     busy,
  output logic                     done
`ifdef GCN_SEQ_PERF_EN
  , output logic [15:0]            perf_cycles
`endif
);

  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(READ_LATENCY - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(FEATURE_ROWS - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(WEIGHT_COLS - 1);
  localparam logic [COO_BW-1:0] EDGE_LAST = COO_BW'(COO_NUM_OF_COLS - 1);

  gcn_seq_state_t state_q, state_nxt;
  logic [COL_W-1:0]  col_q, col_nxt;
  logic [ROW_W-1:0]  row_q, row_nxt;
  logic [COO_BW-1:0] edge_q, edge_nxt;
  logic [LAT_W-1:0]  lat_q, lat_nxt;

  logic [ADDRESS_WIDTH-1:0] read_address_nxt;
  logic [COO_BW-1:0]        coo_address_nxt;
  logic [ROW_W-1:0]         class_row_nxt;
  logic enable_read_nxt, wm_load_en_nxt, class_en_nxt, busy_nxt, done_nxt;

  // Issue-side tags feeding the two delay lines
  logic             f_issue_q, f_issue_nxt;
  logic [ROW_W-1:0] f_row_q, f_row_nxt;
  logic [COL_W-1:0] f_col_q, f_col_nxt;
  logic             a_issue_q, a_issue_nxt;

  logic [ROW_W+COL_W-1:0] f_dl_data;
  logic                   agg_vld, agg_tag;

`ifdef GCN_SEQ_PERF_EN
  logic [15:0] perf_nxt;
`endif

  always_comb begin
    state_nxt        = state_q;
    col_nxt          = col_q;
    row_nxt          = row_q;
    edge_nxt         = edge_q;
    lat_nxt          = lat_q;
    read_address_nxt = read_address;
    coo_address_nxt  = coo_address;
    class_row_nxt    = class_row;
    enable_read_nxt  = 1'b0;
    wm_load_en_nxt   = 1'b0;
    class_en_nxt     = 1'b0;
    f_issue_nxt      = 1'b0;
    f_row_nxt        = f_row_q;
    f_col_nxt        = f_col_q;
    a_issue_nxt      = 1'b0;
    busy_nxt         = (state_q != IDLE) && (state_q != DONE);
    done_nxt         = (state_q == DONE);

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = LOAD_W;
          col_nxt   = '0;
          row_nxt   = '0;
          edge_nxt  = '0;
          lat_nxt   = '0;
        end
      end
      LOAD_W: begin
        enable_read_nxt  = 1'b1;
        read_address_nxt = ADDRESS_WIDTH'(col_q);
        lat_nxt          = '0;
        state_nxt        = WAIT_W;
      end
      WAIT_W: begin
        if (lat_q == LAT_LAST) begin
          wm_load_en_nxt = 1'b1;
          lat_nxt        = '0;
          row_nxt        = '0;
          state_nxt      = READ_F;
        end else begin
          lat_nxt = lat_q + LAT_W'(1);
        end
      end
      READ_F: begin
        enable_read_nxt  = 1'b1;
        read_address_nxt = ADDRESS_WIDTH'(FEATURE_BASE_ADDR) + ADDRESS_WIDTH'(row_q);
        f_issue_nxt      = 1'b1;
        f_row_nxt        = row_q;
        f_col_nxt        = col_q;
        if (row_q == ROW_LAST) begin
          row_nxt   = '0;
          lat_nxt   = '0;
          state_nxt = DRAIN_F;
        end else begin
          row_nxt = row_q + ROW_W'(1);
        end
      end
      // Scratch pad is reloaded only once all products of this column are written
      DRAIN_F: begin
        if (lat_q == LAT_LAST) begin
          lat_nxt = '0;
          if (col_q == COL_LAST) begin
            edge_nxt  = '0;
            state_nxt = AGG;
          end else begin
            col_nxt   = col_q + COL_W'(1);
            state_nxt = LOAD_W;
          end
        end else begin
          lat_nxt = lat_q + LAT_W'(1);
        end
      end
      AGG: begin
        coo_address_nxt = edge_q;
        a_issue_nxt     = 1'b1;
        if (edge_q == EDGE_LAST) begin
          edge_nxt  = '0;
          lat_nxt   = '0;
          state_nxt = DRAIN_A;
        end else begin
          edge_nxt = edge_q + COO_BW'(1);
        end
      end
      DRAIN_A: begin
        if (lat_q == LAT_LAST) begin
          lat_nxt   = '0;
          row_nxt   = '0;
          state_nxt = CLASS;
        end else begin
          lat_nxt = lat_q + LAT_W'(1);
        end
      end
      CLASS: begin
        class_en_nxt  = 1'b1;
        class_row_nxt = row_q;
        if (row_q == ROW_LAST) begin
          row_nxt   = '0;
          state_nxt = DONE;
        end else begin
          row_nxt = row_q + ROW_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

`ifdef GCN_SEQ_PERF_EN
    perf_nxt = perf_cycles;
    if (((state_q == IDLE) || (state_q == DONE)) && start) begin
      perf_nxt = '0;
    end else if (busy && (perf_cycles != 16'hFFFF)) begin
      perf_nxt = perf_cycles + 16'd1;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      edge_q       <= '0;
      lat_q        <= '0;
      read_address <= '0;
      enable_read  <= 1'b0;
      coo_address  <= '0;
      wm_load_en   <= 1'b0;
      class_en     <= 1'b0;
      class_row    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      f_issue_q    <= 1'b0;
      f_row_q      <= '0;
      f_col_q      <= '0;
      a_issue_q    <= 1'b0;
`ifdef GCN_SEQ_PERF_EN
      perf_cycles  <= '0;
`endif
    end else begin
      state_q      <= state_nxt;
      col_q        <= col_nxt;
      row_q        <= row_nxt;
      edge_q       <= edge_nxt;
      lat_q        <= lat_nxt;
      read_address <= read_address_nxt;
      enable_read  <= enable_read_nxt;
      coo_address  <= coo_address_nxt;
      wm_load_en   <= wm_load_en_nxt;
      class_en     <= class_en_nxt;
      class_row    <= class_row_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
      f_issue_q    <= f_issue_nxt;
      f_row_q      <= f_row_nxt;
      f_col_q      <= f_col_nxt;
      a_issue_q    <= a_issue_nxt;
`ifdef GCN_SEQ_PERF_EN
      perf_cycles  <= perf_nxt;
`endif
    end
  end

  // Product write lands READ_LATENCY cycles after its feature read
  gcn_seq_delay_line #(
    .DEPTH(READ_LATENCY),
    .WIDTH(ROW_W + COL_W)
  ) u_fm_dly (
    .clk      (clk),
    .rst_n    (reset),
    .in_valid (f_issue_q),
    .in_data  ({f_row_q, f_col_q}),
    .out_valid(fm_wm_wr_en),
    .out_data (f_dl_data)
  );

  assign {fm_wm_wr_row, fm_wm_wr_col} = f_dl_data;

  gcn_seq_delay_line #(
    .DEPTH(READ_LATENCY),
    .WIDTH(1)
  ) u_agg_dly (
    .clk      (clk),
    .rst_n    (reset),
    .in_valid (a_issue_q),
    .in_data  (a_issue_q),
    .out_valid(agg_vld),
    .out_data (agg_tag)
  );

  assign agg_wr_en = agg_vld & agg_tag;

endmodule

// File: tb/tb_gcn_phase_sequencer.sv
// Directed bench: sequence order, latency alignment, stray starts, abort, restart, latency 4.
module tb_gcn_phase_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic start, start4;
  int   cyc = 0;

  logic [12:0] read_address, read_address4;
  logic        enable_read, enable_read4;
  logic [2:0]  coo_address, coo_address4;
  logic        wm_load_en, wm_load_en4;
  logic        fm_wm_wr_en, fm_wm_wr_en4;
  logic [2:0]  fm_wm_wr_row, fm_wm_wr_row4;
  logic [1:0]  fm_wm_wr_col, fm_wm_wr_col4;
  logic        agg_wr_en, agg_wr_en4;
  logic        class_en, class_en4;
  logic [2:0]  class_row, class_row4;
  logic        busy, busy4;
  logic        done, done4;
`ifdef GCN_SEQ_PERF_EN
  logic [15:0] perf_cycles, perf_cycles4;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gcn_phase_sequencer dut (
    .clk(clk), .reset(rst_n), .start(start),
    .read_address(read_address), .enable_read(enable_read), .coo_address(coo_address),
    .wm_load_en(wm_load_en), .fm_wm_wr_en(fm_wm_wr_en), .fm_wm_wr_row(fm_wm_wr_row),
    .fm_wm_wr_col(fm_wm_wr_col), .agg_wr_en(agg_wr_en), .class_en(class_en),
    .class_row(class_row), .busy(busy), .done(done)
`ifdef GCN_SEQ_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  gcn_phase_sequencer #(.READ_LATENCY(4)) dut4 (
    .clk(clk), .reset(rst_n), .start(start4),
    .read_address(read_address4), .enable_read(enable_read4), .coo_address(coo_address4),
    .wm_load_en(wm_load_en4), .fm_wm_wr_en(fm_wm_wr_en4), .fm_wm_wr_row(fm_wm_wr_row4),
    .fm_wm_wr_col(fm_wm_wr_col4), .agg_wr_en(agg_wr_en4), .class_en(class_en4),
    .class_row(class_row4), .busy(busy4), .done(done4)
`ifdef GCN_SEQ_PERF_EN
    , .perf_cycles(perf_cycles4)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Monitor for the latency-2 instance
  logic        en_hist   [256];
  logic [12:0] addr_hist [256];
  logic [2:0]  coo_hist  [256];
  int          rd_q [$];
  int          wr_q [$];
  int          cls_q [$];
  int          wm_n  = 0;
  int          agg_n = 0;

  always @(negedge clk) begin
    en_hist[8'(cyc)]   = enable_read;
    addr_hist[8'(cyc)] = read_address;
    coo_hist[8'(cyc)]  = coo_address;
    if (enable_read) rd_q.push_back(int'(read_address));
    if (wm_load_en) begin
      chk("wm_lat_en", 32'(en_hist[8'(cyc - 2)]), 32'd1);
      chk("wm_lat_addr", 32'(addr_hist[8'(cyc - 2)]), 32'(wm_n));
      wm_n++;
    end
    if (fm_wm_wr_en) begin
      chk("wr_lat_en", 32'(en_hist[8'(cyc - 2)]), 32'd1);
      chk("wr_lat_addr", 32'(addr_hist[8'(cyc - 2)]), 32'(512 + int'(fm_wm_wr_row)));
      wr_q.push_back(int'(fm_wm_wr_row) * 4 + int'(fm_wm_wr_col));
    end
    if (agg_wr_en) begin
      chk("agg_lat", 32'(coo_hist[8'(cyc - 2)]), 32'(agg_n));
      agg_n++;
    end
    if (class_en) cls_q.push_back(int'(class_row));
  end

  // Monitor for the latency-4 instance
  int w4_cyc [$];
  int wr4_n = 0;
  int wm4_n = 0;
  int rdf4_first = -1;
  int wr4_first  = -1;

  always @(negedge clk) begin
    if (enable_read4 && read_address4 < 13'd3) w4_cyc.push_back(cyc);
    if (enable_read4 && read_address4 >= 13'd512 && rdf4_first < 0) rdf4_first = cyc;
    if (wm_load_en4) begin
      chk("l4_no_pending", 32'(fm_wm_wr_en4), 32'd0);
      chk("l4_drained", 32'(wr4_n), 32'(6 * wm4_n));
      wm4_n++;
    end
    if (fm_wm_wr_en4) begin
      if (wr4_first < 0) wr4_first = cyc;
      wr4_n++;
    end
  end

  task automatic clear_mon();
    rd_q.delete();
    wr_q.delete();
    cls_q.delete();
    wm_n  = 0;
    agg_n = 0;
  endtask

  task automatic pulse(output int s);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    s = cyc;
  endtask

  // Waits for done to rise; raises start at the given offsets from s
  task automatic run_seq(input int s, input int ign1, input int ign2, output int dly);
    bit low = 1'b0;
    dly = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((cyc - s == ign1) || (cyc - s == ign2)) begin
        chk("busy_at_stray", 32'(busy), 32'd1);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (!done) low = 1'b1;
      else if (low) begin
        dly = cyc - s;
`ifdef GCN_SEQ_PERF_EN
        chk("perf_at_done", 32'(perf_cycles), 32'd47);
`endif
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_seq(input string tag);
    int k = 0;
    chk({tag, "_rd_n"}, 32'(rd_q.size()), 32'd21);
    for (int c = 0; c < 3; c++) begin
      if (k < rd_q.size()) chk({tag, "_rd_w"}, 32'(rd_q[k]), 32'(c));
      k++;
      for (int r = 0; r < 6; r++) begin
        if (k < rd_q.size()) chk({tag, "_rd_f"}, 32'(rd_q[k]), 32'(512 + r));
        k++;
      end
    end
    chk({tag, "_wr_n"}, 32'(wr_q.size()), 32'd18);
    for (int i = 0; i < wr_q.size() && i < 18; i++)
      chk({tag, "_wr_rc"}, 32'(wr_q[i]), 32'((i % 6) * 4 + (i / 6)));
    chk({tag, "_wm_n"}, 32'(wm_n), 32'd3);
    chk({tag, "_agg_n"}, 32'(agg_n), 32'd6);
    chk({tag, "_cls_n"}, 32'(cls_q.size()), 32'd6);
    for (int i = 0; i < cls_q.size() && i < 6; i++)
      chk({tag, "_cls_row"}, 32'(cls_q[i]), 32'(i));
  endtask

  initial begin
    int  s, d;
    bit  found;
    rst_n  = 1'b0;
    start  = 1'b0;
    start4 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outs", 32'({enable_read, read_address, coo_address, wm_load_en, fm_wm_wr_en,
        fm_wm_wr_row, fm_wm_wr_col, agg_wr_en, class_en, class_row, busy, done}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy_done", 32'({busy, done, enable_read}), 32'd0);

    // Single run from IDLE
    clear_mon();
    pulse(s);
    run_seq(s, -1, -1, d);
    chk("done_dly_run1", 32'(d), 32'd48);
    check_seq("run1");

    // Restart from DONE with stray starts while busy
    clear_mon();
    pulse(s);
    run_seq(s, 5, 30, d);
    chk("done_dly_stray", 32'(d), 32'd48);
    check_seq("stray");

    // Abort during READ_F of column 1
    clear_mon();
    pulse(s);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (enable_read && read_address == 13'd513) found = 1'b1;
    end
    chk("abort_reached", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_outs", 32'({enable_read, read_address, coo_address, wm_load_en, fm_wm_wr_en,
        fm_wm_wr_row, fm_wm_wr_col, agg_wr_en, class_en, class_row, busy, done}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_quiet", 32'({enable_read, wm_load_en, fm_wm_wr_en, agg_wr_en, class_en, busy}), 32'd0);
    end
    rst_n = 1'b1;
    clear_mon();
    pulse(s);
    run_seq(s, -1, -1, d);
    chk("done_dly_after_abort", 32'(d), 32'd48);
    check_seq("abort");

    // Start held high in DONE restarts immediately
    clear_mon();
    @(negedge clk) start = 1'b1;
    @(negedge clk) s = cyc;
    @(negedge clk);
    chk("hold_done_drop", 32'({done, busy, enable_read}), 32'b011);
    chk("hold_first_addr", 32'(read_address), 32'd0);
    start = 1'b0;
    run_seq(s, -1, -1, d);
    chk("done_dly_hold", 32'(d), 32'd48);
    check_seq("hold");

    // Latency-4 instance
    @(negedge clk) start4 = 1'b1;
    @(negedge clk) start4 = 1'b0;
    s = cyc;
    d = -1;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (done4) begin
        d = cyc - s;
`ifdef GCN_SEQ_PERF_EN
        chk("l4_perf", 32'(perf_cycles4), 32'd61);
`endif
        break;
      end
    end
    chk("l4_done_dly", 32'(d), 32'd62);
    chk("l4_wreads", 32'(w4_cyc.size()), 32'd3);
    if (w4_cyc.size() == 3) begin
      chk("l4_col_len0", 32'(w4_cyc[1] - w4_cyc[0]), 32'd15);
      chk("l4_col_len1", 32'(w4_cyc[2] - w4_cyc[1]), 32'd15);
    end
    chk("l4_wr_lat", 32'(wr4_first - rdf4_first), 32'd4);
    chk("l4_wm_n", 32'(wm4_n), 32'd3);
    chk("l4_wr_n", 32'(wr4_n), 32'd18);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
